init_sequencer: RTL and testbench

Power-on configuration sequencer for a memory-mapped peripheral register bus. After reset it walks a parameterized table of (address, data) words, writes each one to the bus with a valid/ready handshake, retries on error or timeout, and then reports INITIALIZED. Once initialized it hands the bus to the CPU-side port as a transparent pass-through, so it acts as the owner and arbiter of the peripheral bus between the boot sequence and the core.

---
 rtl/init_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_init_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/init_sequencer.sv
// init_sequencer: boot-time register writer and owner of the peripheral bus.
// Walks an (address, data) table through a valid/ready bus. Each word is
// retried on an error response or a timeout. Once the whole table is written,
// the bus becomes a transparent pass-through for the CPU-side port.
module init_sequencer #(
  parameter int NUM_WORDS = 8,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [7:0]        tbl_idx,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic              bus_err,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic              initialized,
  output logic              not_initialized,
  output logic              init_error,
  output logic              busy
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int RC_W = $clog2(MAX_RETRY + 1);
  localparam logic [7:0]      LAST_IDX = 8'(NUM_WORDS - 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
  localparam logic [RC_W-1:0] RC_LIMIT = RC_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    RETRY,
    DONE,
    FAIL
  } state_t;

  state_t              state_reg;
  logic [7:0]          idx_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [TO_W-1:0]     to_cnt_reg;
  logic [RC_W-1:0]     rc_reg;
  logic                pend_reg;
  logic                valid_reg;
  logic                init_reg;
  logic                ierr_reg;
  logic                busy_reg;

  logic [TO_W-1:0]     to_inc;
  logic [RC_W-1:0]     rc_inc;
  logic                start_req;
  logic                accepted;
  logic                rejected;
  logic                expired;

  // Handshake outcome decode for the word currently being written.
  always_comb begin
    to_inc    = to_cnt_reg + 1'b1;
    rc_inc    = rc_reg + 1'b1;
    // A start pulse counts in the same cycle it arrives, so a restart does
    // not have to wait an extra cycle for the pending flag.
    start_req = pend_reg | start;
    accepted  = bus_ready & ~bus_err;
    rejected  = bus_ready & bus_err;
    // This is the TIMEOUT-th cycle without ready. Valid has then been high
    // for exactly TIMEOUT cycles.
    expired   = ~bus_ready & (to_inc == TO_LIMIT);
  end

  // Sequencer FSM. Status outputs are registered together with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      addr_reg   <= '0;
      data_reg   <= '0;
      to_cnt_reg <= '0;
      rc_reg     <= '0;
      pend_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      init_reg   <= 1'b0;
      ierr_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      // Remember restart requests from any state. A consuming state below
      // overrides this assignment.
      if (start) begin
        pend_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          state_reg <= LOAD;
          idx_reg   <= '0;
          pend_reg  <= 1'b0;
          busy_reg  <= 1'b1;
        end
        LOAD: begin
          addr_reg   <= tbl_addr;
          data_reg   <= tbl_data;
          to_cnt_reg <= '0;
          valid_reg  <= 1'b1;
          state_reg  <= WRITE;
        end
        WRITE: begin
          if (accepted) begin
            rc_reg    <= '0;
            valid_reg <= 1'b0;
            if (idx_reg == LAST_IDX) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              init_reg  <= 1'b1;
            end else begin
              idx_reg   <= idx_reg + 8'd1;
              state_reg <= LOAD;
            end
          end else if (rejected || expired) begin
            rc_reg    <= rc_inc;
            valid_reg <= 1'b0;
            if (rc_inc == RC_LIMIT) begin
              state_reg <= FAIL;
              busy_reg  <= 1'b0;
              ierr_reg  <= 1'b1;
            end else begin
              state_reg <= RETRY;
            end
          end else if (!bus_ready) begin
            to_cnt_reg <= to_inc;
          end
        end
        RETRY: begin
          to_cnt_reg <= '0;
          valid_reg  <= 1'b1;
          state_reg  <= WRITE;
        end
        DONE: begin
          // Restart only between CPU transactions, so an in-flight CPU
          // request is never cut off.
          if (start_req && !cpu_valid) begin
            pend_reg  <= 1'b0;
            idx_reg   <= '0;
            rc_reg    <= '0;
            init_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= LOAD;
          end
        end
        FAIL: begin
          if (start_req) begin
            pend_reg  <= 1'b0;
            idx_reg   <= '0;
            rc_reg    <= '0;
            ierr_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= LOAD;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Bus ownership mux. The CPU drives the bus only once initialized.
  always_comb begin
    tbl_idx         = idx_reg;
    initialized     = init_reg;
    not_initialized = ~init_reg;
    init_error      = ierr_reg;
    busy            = busy_reg;
    bus_valid       = valid_reg;
    bus_addr        = addr_reg;
    bus_wdata       = data_reg;
    cpu_ready       = 1'b0;
    cpu_err         = 1'b0;
    if (init_reg) begin
      bus_valid = cpu_valid;
      bus_addr  = cpu_addr;
      bus_wdata = cpu_wdata;
      cpu_ready = bus_ready;
      cpu_err   = bus_err;
    end
  end

endmodule

// File: tb/tb_init_sequencer.sv
// Directed testbench for init_sequencer (4 words, TIMEOUT 5, MAX_RETRY 3).
module tb_init_sequencer;

  localparam logic [31:0] CPU_WD = 32'h5A5A_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  tbl_idx;
  logic [7:0]  tbl_addr;
  logic [31:0] tbl_data;
  logic        bus_valid;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic        bus_err;
  logic        cpu_valid;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        initialized;
  logic        not_initialized;
  logic        init_error;
  logic        busy;

  logic [7:0]  tab_a [0:3] = '{8'hA0, 8'hA4, 8'hA8, 8'hAC};
  logic [31:0] tab_d [0:3] = '{32'hDEAD_0000, 32'hBEEF_0001, 32'hCAFE_0002, 32'hF00D_0003};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign tbl_addr = tab_a[tbl_idx[1:0]];
  assign tbl_data = tab_d[tbl_idx[1:0]];

  init_sequencer #(
    .NUM_WORDS(4),
    .ADDR_W   (8),
    .DATA_W   (32),
    .TIMEOUT  (5),
    .MAX_RETRY(3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .tbl_idx        (tbl_idx),
    .tbl_addr       (tbl_addr),
    .tbl_data       (tbl_data),
    .bus_valid      (bus_valid),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_ready      (bus_ready),
    .bus_err        (bus_err),
    .cpu_valid      (cpu_valid),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_ready      (cpu_ready),
    .cpu_err        (cpu_err),
    .initialized    (initialized),
    .not_initialized(not_initialized),
    .init_error     (init_error),
    .busy           (busy)
  );

  typedef struct {
    logic        st;
    logic        rdy;
    logic        err;
    logic        cv;
    logic [7:0]  ca;
    logic        ev;
    logic [7:0]  ea;
    logic [31:0] ew;
    logic [7:0]  ei;
    logic        ecr;
    logic        ece;
    logic        einit;
    logic        eierr;
    logic        ebusy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic st, rdy, err, cv, input logic [7:0] ca,
                     input logic ev, input logic [7:0] ea, input logic [31:0] ew,
                     input logic [7:0] ei, input logic ecr, ece, einit, eierr, ebusy);
    vec_t v;
    v.st = st; v.rdy = rdy; v.err = err; v.cv = cv; v.ca = ca;
    v.ev = ev; v.ea = ea; v.ew = ew; v.ei = ei;
    v.ecr = ecr; v.ece = ece; v.einit = einit; v.eierr = eierr; v.ebusy = ebusy;
    vecs.push_back(v);
  endtask

  // Row helpers: one row describes one clock cycle of inputs and outputs.
  task automatic r_idle();
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 32'h0, 8'd0, 0, 0, 0, 0, 0);
  endtask
  task automatic r_load(input int k, input logic [7:0] pa, input logic [31:0] pd);
    add(0, 1, 0, 1, 8'h10, 0, pa, pd, 8'(k), 0, 0, 0, 0, 1);
  endtask
  task automatic r_write(input int k, input logic rdy, input logic err);
    add(0, rdy, err, 1, 8'h10, 1, tab_a[k], tab_d[k], 8'(k), 0, 0, 0, 0, 1);
  endtask
  task automatic r_retry(input int k);
    add(0, 0, 0, 0, 8'h10, 0, tab_a[k], tab_d[k], 8'(k), 0, 0, 0, 0, 1);
  endtask
  task automatic r_done(input logic cv, input logic [7:0] ca, input logic rdy, input logic err);
    add(0, rdy, err, cv, ca, cv, ca, CPU_WD, 8'd3, rdy, err, 1, 0, 0);
  endtask
  task automatic r_fail(input logic st);
    add(st, 0, 0, 0, 8'h10, 0, tab_a[0], tab_d[0], 8'd0, 0, 0, 0, 1, 0);
  endtask

  task automatic run_vecs(input int scen);
    for (int i = 0; i < vecs.size(); i++) begin
      start     = vecs[i].st;
      bus_ready = vecs[i].rdy;
      bus_err   = vecs[i].err;
      cpu_valid = vecs[i].cv;
      cpu_addr  = vecs[i].ca;
      #1;
      chk($sformatf("s%0d r%0d bus_valid", scen, i), 32'(bus_valid), 32'(vecs[i].ev));
      chk($sformatf("s%0d r%0d bus_addr", scen, i), 32'(bus_addr), 32'(vecs[i].ea));
      chk($sformatf("s%0d r%0d bus_wdata", scen, i), bus_wdata, vecs[i].ew);
      chk($sformatf("s%0d r%0d tbl_idx", scen, i), 32'(tbl_idx), 32'(vecs[i].ei));
      chk($sformatf("s%0d r%0d cpu_ready", scen, i), 32'(cpu_ready), 32'(vecs[i].ecr));
      chk($sformatf("s%0d r%0d cpu_err", scen, i), 32'(cpu_err), 32'(vecs[i].ece));
      chk($sformatf("s%0d r%0d initialized", scen, i), 32'(initialized), 32'(vecs[i].einit));
      chk($sformatf("s%0d r%0d not_initialized", scen, i), 32'(not_initialized), 32'(!vecs[i].einit));
      chk($sformatf("s%0d r%0d init_error", scen, i), 32'(init_error), 32'(vecs[i].eierr));
      chk($sformatf("s%0d r%0d busy", scen, i), 32'(busy), 32'(vecs[i].ebusy));
      $display("scen %0d row %0d: valid=%b addr=%h idx=%0d init=%b ierr=%b busy=%b",
               scen, i, bus_valid, bus_addr, tbl_idx, initialized, init_error, busy);
      @(negedge clk);
    end
    start     = 1'b0;
    cpu_valid = 1'b0;
    bus_err   = 1'b0;
    vecs.delete();
  endtask

  // Hold reset for two cycles and release it on a falling edge.
  task automatic do_reset();
    rst       = 1'b1;
    start     = 1'b0;
    bus_ready = 1'b0;
    bus_err   = 1'b0;
    cpu_valid = 1'b0;
    cpu_addr  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    cpu_wdata = CPU_WD;
    rst       = 1'b1;
    start     = 1'b0;
    bus_ready = 1'b0;
    bus_err   = 1'b0;
    cpu_valid = 1'b0;
    cpu_addr  = 8'h00;
    #2;
    chk("reset bus_valid", 32'(bus_valid), 32'd0);
    chk("reset not_initialized", 32'(not_initialized), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset bus_addr", 32'(bus_addr), 32'd0);

    // Scenario 1: clean run, then pass-through in DONE.
    do_reset();
    r_idle();
    r_load(0, 8'h00, 32'h0);
    r_write(0, 1, 0);
    r_load(1, tab_a[0], tab_d[0]);
    r_write(1, 1, 0);
    r_load(2, tab_a[1], tab_d[1]);
    r_write(2, 1, 0);
    r_load(3, tab_a[2], tab_d[2]);
    r_write(3, 1, 0);
    r_done(0, 8'h33, 1, 0);
    r_done(1, 8'h10, 1, 0);
    r_done(1, 8'h10, 1, 1);
    r_done(1, 8'h10, 0, 0);
    run_vecs(1);

    // Start while the CPU is mid-request: the restart must wait for cpu_valid low.
    start     = 1'b1;
    cpu_valid = 1'b1;
    bus_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold initialized c%0d", i), 32'(initialized), 32'd1);
      chk($sformatf("hold busy c%0d", i), 32'(busy), 32'd0);
      @(negedge clk);
    end
    cpu_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("restart busy", 32'(busy), 32'd1);
    chk("restart tbl_idx", 32'(tbl_idx), 32'd0);
    chk("restart initialized", 32'(initialized), 32'd0);
    chk("restart not_initialized", 32'(not_initialized), 32'd1);
    $display("restart after cpu_valid drop: busy=%b idx=%0d init=%b", busy, tbl_idx, initialized);
    bus_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      #1;
      if (initialized) found = 1'b1;
    end
    chk("rerun reaches DONE", 32'(found), 32'd1);

    // Scenario 2: one error response on word 2.
    do_reset();
    r_idle();
    r_load(0, 8'h00, 32'h0);
    r_write(0, 1, 0);
    r_load(1, tab_a[0], tab_d[0]);
    r_write(1, 1, 0);
    r_load(2, tab_a[1], tab_d[1]);
    r_write(2, 1, 1);
    r_retry(2);
    r_write(2, 1, 0);
    r_load(3, tab_a[2], tab_d[2]);
    r_write(3, 1, 0);
    r_done(0, 8'h00, 0, 0);
    run_vecs(2);

    // Scenario 3: ready stuck low, three timeouts, FAIL, then restart by start.
    do_reset();
    r_idle();
    r_load(0, 8'h00, 32'h0);
    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < 5; c++) r_write(0, 0, 0);
      if (b < 2) r_retry(0);
    end
    r_fail(0);
    r_fail(0);
    r_fail(1);
    r_load(0, tab_a[0], tab_d[0]);
    r_write(0, 1, 0);
    r_load(1, tab_a[0], tab_d[0]);
    run_vecs(3);

    // Reset during WRITE of word 3, then a start pulse while busy.
    do_reset();
    bus_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      #1;
      if (tbl_idx == 8'd3 && bus_valid) found = 1'b1;
    end
    chk("reach word3 write", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("async rst bus_valid", 32'(bus_valid), 32'd0);
    chk("async rst tbl_idx", 32'(tbl_idx), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst bus_addr", 32'(bus_addr), 32'd0);
    $display("reset mid-write: valid=%b idx=%0d busy=%b", bus_valid, tbl_idx, busy);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post rst idle busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    chk("post rst load busy", 32'(busy), 32'd1);
    chk("post rst load idx", 32'(tbl_idx), 32'd0);
    @(negedge clk);
    #1;
    chk("post rst write valid", 32'(bus_valid), 32'd1);
    chk("post rst write addr", 32'(bus_addr), 32'(tab_a[0]));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      #1;
      if (initialized) found = 1'b1;
    end
    chk("busy start run DONE", 32'(found), 32'd1);
    @(negedge clk);
    #1;
    chk("pending start rerun busy", 32'(busy), 32'd1);
    chk("pending start rerun idx", 32'(tbl_idx), 32'd0);
    chk("pending start rerun init", 32'(initialized), 32'd0);
    $display("pending start rerun: busy=%b idx=%0d init=%b", busy, tbl_idx, initialized);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
